// File: rtl/regfile_dump_reader_if.sv
// Register-file read port plus the {index, data} output stream of the dump reader.
// The master side belongs to the dump reader and the slave side to the consumer/regfile.
interface regfile_dump_reader_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic [AW-1:0] rn;
    logic [DW-1:0] q;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_idx;
    logic [DW-1:0] out_data;

    modport master (
        output rn,
        input  q,
        output out_valid,
        input  out_ready,
        output out_idx,
        output out_data
    );

    modport slave (
        input  rn,
        output q,
        input  out_valid,
        output out_ready,
        input  out_idx,
        input  out_data
    );
endinterface

// File: rtl/regfile_dump_reader.sv
// Debug dump engine: walks an inclusive register range on a spare read port and
// streams {index, data} words; it only reads the register file and never writes it.
//
//   state | meaning
//   IDLE  | waiting for start; a bad range (first > last) pulses err
//   READ  | rn is stable, capture q into the output word
//   SEND  | hold out_valid until the consumer accepts the word
//   DONE  | single-cycle done pulse, then back to IDLE
module regfile_dump_reader #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic                   i_clk,
    input  logic                   i_clr,
    input  logic                   i_start,
    input  logic [AW-1:0]          i_first,
    input  logic [AW-1:0]          i_last,
    input  logic                   i_abort,
    regfile_dump_reader_if.master  bus,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_err
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_rn;
    logic [AW-1:0] r_last;
    logic [AW-1:0] r_out_idx;
    logic [DW-1:0] r_out_data;
    logic          r_out_valid;
    logic          r_done;
    logic          r_err;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_state     <= IDLE;
            r_rn        <= '0;
            r_last      <= '0;
            r_out_idx   <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        if (i_first <= i_last) begin
                            r_last  <= i_last;
                            r_rn    <= i_first;
                            r_state <= READ;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (i_abort) begin
                        r_state <= IDLE;
                    end else begin
                        r_out_data  <= bus.q;
                        r_out_idx   <= r_rn;
                        r_out_valid <= 1'b1;
                        r_state     <= SEND;
                    end
                end
                SEND: begin
                    // abort wins over a handshake in the same cycle
                    if (i_abort) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end else if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_out_idx == r_last) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_rn    <= r_rn + 1'b1;
                            r_state <= READ;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.rn        = r_rn;
    assign bus.out_valid = r_out_valid;
    assign bus.out_idx   = r_out_idx;
    assign bus.out_data  = r_out_data;
    assign o_busy        = (r_state != IDLE);
    assign o_done        = r_done;
    assign o_err         = r_err;
endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: a register-file model drives q, and a
// scoreboard queue of expected {index, data} words is popped on every accepted word.
module tb_regfile_dump_reader;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          clr;
    logic          start;
    logic          abort;
    logic [AW-1:0] first;
    logic [AW-1:0] last;
    logic          busy;
    logic          done;
    logic          err;

    logic [DW-1:0]    mem [32];
    logic [AW+DW-1:0] sb_q [$];
    logic [AW+DW-1:0] exp_w;
    int               n_checks = 0;
    int               n_fail   = 0;

    regfile_dump_reader_if #(.AW(AW), .DW(DW)) bus ();

    regfile_dump_reader #(.AW(AW), .DW(DW)) dut (
        .i_clk   (clk),
        .i_clr   (clr),
        .i_start (start),
        .i_first (first),
        .i_last  (last),
        .i_abort (abort),
        .bus     (bus),
        .o_busy  (busy),
        .o_done  (done),
        .o_err   (err)
    );

    always #5 clk = ~clk;

    // Register-file read port: register 0 always reads as zero.
    assign bus.q = (bus.rn == '0) ? '0 : mem[bus.rn];

    // Scoreboard: an accepted word is valid && ready without abort or clr.
    always @(negedge clk) begin
        if (!clr && !abort && bus.out_valid && bus.out_ready) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got idx=%0d data=%h, expected no word", bus.out_idx, bus.out_data);
            end else begin
                exp_w = sb_q.pop_front();
                if ({bus.out_idx, bus.out_data} !== exp_w) begin
                    n_fail++;
                    $display("FAIL sb_word: got idx=%0d data=%h, expected idx=%0d data=%h",
                             bus.out_idx, bus.out_data, exp_w[AW+DW-1:DW], exp_w[DW-1:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(input int f, input int l);
        for (int i = f; i <= l; i++)
            sb_q.push_back({AW'(i), (i == 0) ? DW'(0) : mem[i]});
    endtask

    task automatic do_start(input int f, input int l);
        first = AW'(f);
        last  = AW'(l);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n_done, output bit timed_out);
        n_done    = 0;
        timed_out = 1'b1;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (done) n_done++;
            if (!busy) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        clr = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({busy, done, err, bus.out_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got busy/done/err/valid=%b, expected 0000", {busy, done, err, bus.out_valid});
        end
        n_checks++;
        if ({bus.rn, bus.out_idx, bus.out_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got rn=%0d idx=%0d data=%h, expected all 0", bus.rn, bus.out_idx, bus.out_data);
        end
        clr = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        bus.out_ready = 1'b1;
        push_range(1, 3);
        do_start(1, 3);
        n_checks++;
        if (bus.rn !== 5'd1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_start: got rn=%0d busy=%b, expected rn=1 busy=1", bus.rn, busy);
        end
        for (int k = 2; k <= 8; k++) begin
            tick();
            n_checks++;
            if (bus.out_valid !== (k == 2 || k == 4 || k == 6) || done !== (k == 7) || busy !== (k <= 7)) begin
                n_fail++;
                $display("FAIL basic_timing cycle %0d: got valid=%b done=%b busy=%b, expected valid=%b done=%b busy=%b",
                         k, bus.out_valid, done, busy, (k == 2 || k == 4 || k == 6), (k == 7), (k <= 7));
            end
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL basic_drain: got %0d words left, expected 0", sb_q.size());
        end
    endtask

    task automatic test_reg0();
        int n_done;
        bit to;
        mem[0] = 32'hDEADBEEF;
        push_range(0, 0);
        do_start(0, 0);
        wait_done(10, n_done, to);
        n_checks++;
        if (to || n_done != 1 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL reg0: got timeout=%0d done_pulses=%0d left=%0d, expected 0/1/0", to, n_done, sb_q.size());
        end
    endtask

    task automatic test_stall();
        int n_done;
        bit to;
        bit found;
        bus.out_ready = 1'b0;
        push_range(30, 31);
        do_start(30, 31);
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (bus.out_valid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL stall_first_valid: got no out_valid within 10 cycles, expected a word");
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_idx !== 5'd30 || bus.out_data !== mem[30]) begin
                n_fail++;
                $display("FAIL stall_hold %0d: got valid=%b idx=%0d data=%h, expected 1/30/%h",
                         k, bus.out_valid, bus.out_idx, bus.out_data, mem[30]);
            end
        end
        bus.out_ready = 1'b1;
        wait_done(20, n_done, to);
        n_checks++;
        if (to || n_done != 1 || bus.rn !== 5'd31 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL stall_end: got timeout=%0d done_pulses=%0d rn=%0d left=%0d, expected 0/1/31/0",
                     to, n_done, bus.rn, sb_q.size());
        end
    endtask

    task automatic test_err();
        bit bad;
        bus.out_ready = 1'b1;
        do_start(5, 4);
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || bus.rn !== 5'd31) begin
            n_fail++;
            $display("FAIL err_pulse: got err=%b busy=%b done=%b rn=%0d, expected 1/0/0/31", err, busy, done, bus.rn);
        end
        tick();
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_width: got err=%b one cycle later, expected 0", err);
        end
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bus.out_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL err_quiet: got valid or busy high after rejected start, expected both 0");
        end
    endtask

    task automatic test_abort();
        int n_done;
        bit to;
        bit found;
        bit bad;
        for (int i = 1; i < 32; i++) mem[i] = $urandom;
        bus.out_ready = 1'b1;
        push_range(1, 31);
        do_start(1, 31);
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus.out_valid && bus.out_idx == 5'd3) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL abort_reach: got no word with idx 3, expected one");
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_stop: got valid=%b busy=%b done=%b, expected 0/0/0", bus.out_valid, busy, done);
        end
        n_checks++;
        if (sb_q.size() != 29) begin
            n_fail++;
            $display("FAIL abort_count: got %0d words pending, expected 29", sb_q.size());
        end
        sb_q.delete();
        bad = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL abort_idle: got done or busy after abort, expected 0");
        end
        push_range(2, 2);
        do_start(2, 2);
        wait_done(10, n_done, to);
        n_checks++;
        if (to || n_done != 1 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL abort_restart: got timeout=%0d done_pulses=%0d left=%0d, expected 0/1/0", to, n_done, sb_q.size());
        end
    endtask

    task automatic test_clr();
        bit found;
        bit bad;
        bus.out_ready = 1'b0;
        do_start(1, 5);
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (bus.out_valid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL clr_reach: got no out_valid, expected first word");
        end
        do_start(10, 12);
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b1 || bus.out_idx !== 5'd1 || bus.rn !== 5'd1) begin
            n_fail++;
            $display("FAIL busy_start: got err=%b busy=%b idx=%0d rn=%0d, expected 0/1/1/1", err, busy, bus.out_idx, bus.rn);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.rn !== 5'd0 || done !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_mid: got valid=%b busy=%b rn=%0d done=%b err=%b, expected 0/0/0/0/0",
                     bus.out_valid, busy, bus.rn, done, err);
        end
        bus.out_ready = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (busy !== 1'b0 || bus.out_valid !== 1'b0 || done !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL clr_idle: got activity after clr, expected idle");
        end
    endtask

    initial begin
        clr           = 1'b1;
        start         = 1'b0;
        abort         = 1'b0;
        first         = '0;
        last          = '0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        mem[1] = 32'h11111111;
        mem[2] = 32'h22222222;
        mem[3] = 32'h33333333;

        test_reset();
        test_basic();
        test_reg0();
        test_stall();
        test_err();
        test_abort();
        test_clr();

        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_final: got %0d words left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
